// File: rtl/snail_tx_pkg.sv
// Shared definitions for the snail_tx_010 serial frame transmitter:
// state encodings and the frame marker.
package snail_tx_pkg;

  localparam int unsigned STATE_W = 3;

  // State encodings
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_PRE0  = 3'd1;
  localparam logic [STATE_W-1:0] ST_PRE1  = 3'd2;
  localparam logic [STATE_W-1:0] ST_PRE2  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DATA  = 3'd4;
  localparam logic [STATE_W-1:0] ST_STUFF = 3'd5;
  localparam logic [STATE_W-1:0] ST_GAP   = 3'd6;

  typedef enum logic [STATE_W-1:0] {
    StIdle  = ST_IDLE,
    StPre0  = ST_PRE0,
    StPre1  = ST_PRE1,
    StPre2  = ST_PRE2,
    StData  = ST_DATA,
    StStuff = ST_STUFF,
    StGap   = ST_GAP
  } state_e;

  // Frame marker, sent MSB first (PRE0 carries bit 2)
  localparam logic [2:0]  MARKER     = 3'b010;
  localparam int unsigned MARKER_LEN = 3;

  // Marker bit for marker position idx (0 = first bit on the line)
  function automatic logic marker_bit(input logic [1:0] idx);
    logic [2:0] m;
    m = MARKER;
    return m[2'd2 - idx];
  endfunction

endpackage

// File: rtl/snail_tx_010_if.sv
// Producer-side bus of the snail_tx_010 transmitter: word handshake plus the
// serial line and status outputs.
interface snail_tx_010_if #(
  parameter int unsigned W = 8
);

  logic [W-1:0] data_in;
  logic         valid_in;
  logic         ready_out;
  logic         tx_out;
  logic         busy;
  logic         done;

  // Producer / line observer
  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  tx_out,
    input  busy,
    input  done
  );

  // Transmitter
  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output tx_out,
    output busy,
    output done
  );

endinterface

// File: rtl/snail_piso.sv
// Parallel-in/serial-out shift register with a down-counting bit counter.
// o_msb is the bit on the line now; o_msb_next is the bit after one shift.
module snail_piso #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb,
  output logic         o_msb_next,
  output logic         o_last_bit
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  r_sr;
  logic [W-1:0]  w_sr_shl;
  logic [CW-1:0] r_cnt;

  assign w_sr_shl = r_sr << 1;

  // Shift register and bit counter: load wins over shift
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sr  <= i_data;
      r_cnt <= CW'(W - 1);
    end else if (i_shift) begin
      r_sr  <= w_sr_shl;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_msb      = r_sr[W-1];
  assign o_msb_next = w_sr_shl[W-1];
  assign o_last_bit = (r_cnt == '0);

endmodule

// File: rtl/snail_tx_010.sv
// Serial frame transmitter: 010 marker, W-bit payload MSB first, then
// GAP_LEN idle-high bits. One word accepted per frame on valid/ready.
// Optional bit stuffing under `SNAIL_TX_STUFF_EN: a 1 is inserted after every
// 0,1 pair on the line so 010 only ever appears as the marker.
// All outputs are flops fed from next-state decode.
module snail_tx_010
  import snail_tx_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned GAP_LEN = 2
) (
  input logic           clk,
  input logic           rst,
  snail_tx_010_if.slave bus
);

  localparam int unsigned GW = $clog2(GAP_LEN + 1);

  state_e        r_state;
  state_e        w_state_d;
  logic [GW-1:0] r_gap;
  logic [GW-1:0] w_gap_d;
  logic          r_tx;
  logic          w_tx_d;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;
  logic          w_load;
  logic          w_shift;
  logic          w_msb;
  logic          w_msb_next;
  logic          w_last;

  snail_piso #(
    .W (W)
  ) u_piso (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_data     (bus.data_in),
    .o_msb      (w_msb),
    .o_msb_next (w_msb_next),
    .o_last_bit (w_last)
  );

`ifdef SNAIL_TX_STUFF_EN
  // Last two bits on the line, including the one driven this cycle
  logic [1:0] r_hist;

  // Line history tracks the registered line bit exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_tx_d};
    end
  end
`endif

  // Next-state logic; shift happens when leaving a payload bit or a stuff bit
  always_comb begin
    w_state_d = r_state;
    w_gap_d   = r_gap;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.valid_in && r_ready) begin
          w_load    = 1'b1;
          w_state_d = StPre0;
        end
      end
      StPre0: w_state_d = StPre1;
      StPre1: w_state_d = StPre2;
      StPre2: w_state_d = StData;
      StData: begin
`ifdef SNAIL_TX_STUFF_EN
        if (r_hist == 2'b01) begin
          // Hold the payload bit position; resume after the stuff bit
          w_state_d = StStuff;
        end else
`endif
        if (w_last) begin
          w_state_d = StGap;
          w_gap_d   = GW'(GAP_LEN - 1);
        end else begin
          w_shift = 1'b1;
        end
      end
`ifdef SNAIL_TX_STUFF_EN
      StStuff: begin
        if (w_last) begin
          w_state_d = StGap;
          w_gap_d   = GW'(GAP_LEN - 1);
        end else begin
          w_shift   = 1'b1;
          w_state_d = StData;
        end
      end
`endif
      StGap: begin
        if (r_gap == '0) begin
          w_state_d = StIdle;
        end else begin
          w_gap_d = r_gap - 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Line bit for the state entered at the next edge
  always_comb begin
    w_tx_d = 1'b1;
    unique case (w_state_d)
      StPre0:  w_tx_d = marker_bit(2'd0);
      StPre1:  w_tx_d = marker_bit(2'd1);
      StPre2:  w_tx_d = marker_bit(2'd2);
      StData:  w_tx_d = w_shift ? w_msb_next : w_msb;
      default: w_tx_d = 1'b1;
    endcase
  end

  // State and output registers; reset aborts any frame without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_gap   <= '0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_gap   <= w_gap_d;
      r_tx    <= w_tx_d;
      r_ready <= (w_state_d == StIdle);
      r_busy  <= (w_state_d != StIdle);
      r_done  <= (w_state_d == StGap) && (r_state != StGap);
    end
  end

  assign bus.tx_out    = r_tx;
  assign bus.ready_out = r_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_snail_tx_010.sv
// Directed bench for snail_tx_010 (W=8, GAP_LEN=2): table of frames with
// hand-derived line patterns plus back-to-back and mid-frame reset sequences.
module tb_snail_tx_010;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  snail_tx_010_if #(.W(8)) bus ();

  snail_tx_010 #(
    .W       (8),
    .GAP_LEN (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // line: expected tx_out bits, first cycle after accept in bit [len-1]
  typedef struct {
    string       name;
    logic [7:0]  data;
    int          len;
    logic [16:0] line;
    int          done_k;
  } vec_t;

  vec_t tbl[$];
  vec_t v00, vff, v3c;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_idle(input string nm);
    @(negedge clk);
    chk({nm, " tx"},    32'(bus.tx_out),    32'd1);
    chk({nm, " ready"}, 32'(bus.ready_out), 32'd1);
    chk({nm, " busy"},  32'(bus.busy),      32'd0);
    chk({nm, " done"},  32'(bus.done),      32'd0);
  endtask

  // Present a word and return just after the accepting edge
  task automatic start(input logic [7:0] d, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.ready_out !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready before accept", 32'(bus.ready_out), 32'd1);
    bus.data_in  = d;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.valid_in = 1'b0;
      bus.data_in  = ~d;
    end
  endtask

  task automatic check_frame(input vec_t v);
`ifdef SNAIL_TX_STUFF_EN
    logic [2:0] h;
    int hits;
    h    = 3'b111;
    hits = 0;
`endif
    for (int k = 1; k <= v.len; k++) begin
      @(negedge clk);
      chk($sformatf("%s tx c%0d", v.name, k), 32'(bus.tx_out), 32'(v.line[v.len-k]));
      chk($sformatf("%s done c%0d", v.name, k), 32'(bus.done), 32'(k == v.done_k));
      chk($sformatf("%s busy c%0d", v.name, k), 32'(bus.busy), 32'd1);
      chk($sformatf("%s ready c%0d", v.name, k), 32'(bus.ready_out), 32'd0);
`ifdef SNAIL_TX_STUFF_EN
      h = {h[1:0], bus.tx_out};
      if (h == 3'b010) hits++;
`endif
    end
`ifdef SNAIL_TX_STUFF_EN
    chk({v.name, " 010 count"}, 32'(hits), 32'd1);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;

    v00 = '{"x00", 8'h00, 13, 17'b0100000000011, 12};
`ifdef SNAIL_TX_STUFF_EN
    vff = '{"xFF", 8'hFF, 14, 17'b01011111111111, 13};
    v3c = '{"x3C", 8'h3C, 14, 17'b01000111110011, 13};
    tbl.push_back('{"x50", 8'h50, 15, 17'b010011011000011, 14});
    tbl.push_back('{"x80", 8'h80, 14, 17'b01011000000011, 13});
    rc = 9;
`else
    vff = '{"xFF", 8'hFF, 13, 17'b0101111111111, 12};
    v3c = '{"x3C", 8'h3C, 13, 17'b0100011110011, 12};
    tbl.push_back('{"xA5", 8'hA5, 13, 17'b0101010010111, 12});
    tbl.push_back('{"x01", 8'h01, 13, 17'b0100000000111, 12});
    rc = 8;
`endif
    tbl.push_back(v00);
    tbl.push_back(vff);
    tbl.push_back(v3c);

    // Reset values while reset is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset tx",    32'(bus.tx_out),    32'd1);
    chk("reset ready", 32'(bus.ready_out), 32'd1);
    chk("reset busy",  32'(bus.busy),      32'd0);
    chk("reset done",  32'(bus.done),      32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) check_idle("idle");

    // Single frames from the table
    foreach (tbl[i]) begin
      start(tbl[i].data, 1'b0);
      check_frame(tbl[i]);
      check_idle({tbl[i].name, " after"});
    end

    // Held valid: 00 then FF, data changes mid-frame are ignored
    @(negedge clk);
    bus.data_in  = 8'h00;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1 bus.data_in = 8'hFF;
    check_frame(v00);
    check_idle("b2b between");
    @(posedge clk);
    #1;
    bus.data_in  = 8'h00;
    bus.valid_in = 1'b0;
    check_frame(vff);
    check_idle("b2b after");

    // Reset during the payload cycle carrying bit 3 of 8'h3C
    start(8'h3C, 1'b0);
    for (int k = 1; k <= rc; k++) begin
      @(negedge clk);
      chk($sformatf("abort tx c%0d", k), 32'(bus.tx_out), 32'(v3c.line[v3c.len-k]));
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) check_idle("abort idle");
    start(8'h3C, 1'b0);
    check_frame(v3c);
    check_idle("x3C clean after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/snail_tx_010.md
Name: snail_tx_010

Overview:
- Serial frame transmitter, the counterpart of the 010 sequence detector. It emits a 3-bit 010 marker on a single-bit line, then a parallel word MSB-first, then idle-high gap bits.
- Loopback partner for the detector benches, and the bit source for the serial link in the lab top level.
- Accepts one word per frame via a valid/ready handshake.

Parameters:
- W, 8, payload width in bits (W >= 1).
- GAP_LEN, 2, number of idle '1' bits sent after each payload before ready_out rises again (GAP_LEN >= 1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- data_in  in  W  payload word; sampled only on an accepting edge.
- valid_in  in  1  producer has a word.
- ready_out  out  1  transmitter is idle and can accept a word.
- tx_out  out  1  serial line; idle level is 1.
- busy  out  1  a frame is in progress (marker, payload, stuff or gap).
- done  out  1  one-cycle pulse marking the end of the payload.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, tx_out=1, ready_out=1, busy=0, done=0. Reset wins over every other event.
- Reset asserted mid-frame aborts the frame. At the next edge tx_out=1, and no done pulse is issued.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Accept: on an edge where state=IDLE and valid_in=1 and ready_out=1:
  - data_in is latched into the shift register;
  - state goes to PRE0, ready_out=0, busy=1.
- data_in and valid_in are ignored outside IDLE. A held valid_in starts the next frame on the first IDLE edge.
- States and the bit driven on tx_out in each, one state per cycle:
  - IDLE: tx_out=1.
  - PRE0: 0.
  - PRE1: 1.
  - PRE2: 0.
  - DATA: current MSB of the shift register. Stay in DATA for W cycles, shifting left; the bit counter runs W-1 down to 0.
  - GAP: 1 for GAP_LEN cycles, then return to IDLE with ready_out=1.
- Cycle timing:
  - The first marker bit appears on tx_out in the cycle after the accepting edge.
  - Frame length without stuffing is 3+W+GAP_LEN cycles. With W=8 and GAP_LEN=2 that is 13 cycles; ready_out is high in the 14th cycle.
- done: high during the first GAP cycle only.
- Back-to-back frames: ready_out is high for at least one IDLE cycle between frames, so the line shows GAP_LEN+1 ones between frames.
- All-zero and all-one payloads are legal and need no special handling.

Optional Feature:
- Macro: SNAIL_TX_STUFF_EN.
- Defined: bit stuffing, so the 010 pattern cannot occur outside the marker.
  - A 2-bit history register holds the last two line bits. It is initialised to "x0" at DATA entry, i.e. the last marker bit.
  - Whenever the last two bits sent were 0 then 1 (including across the marker/payload boundary and after the final payload bit), the next cycle is spent in state STUFF, driving tx_out=1.
  - The shift register and bit counter are held during STUFF.
  - After STUFF the history is "11".
  - done is still issued in the first GAP cycle, i.e. after any trailing stuff bit.
- Undefined: the STUFF state and history logic are absent, and frame length is fixed.

Decomposition:
- Package snail_tx_pkg holds:
  - state encodings (IDLE, PRE0, PRE1, PRE2, DATA, STUFF, GAP) as localparams, 3-bit state;
  - MARKER = 3'b010 and MARKER_LEN = 3.
- One sub-module: snail_piso.
  - Parallel-in/serial-out shift register with load, shift-enable and a bit counter of width $clog2(W+1).
  - Outputs the current MSB and a last_bit flag.
- FSM, stuffing and output registers live in snail_tx_010.

Test Plan:
- Reset, then idle with valid_in=0 for 5 cycles -> tx_out=1, ready_out=1, busy=0 every cycle.
- data_in=8'hA5, single accept (no stuff) -> line 0,1,0,1,0,1,0,0,1,0,1,1,1; done in cycle 12; ready_out=1 in cycle 14.
- valid_in held high with 8'h00 then 8'hFF -> two frames separated by exactly 3 ones; second payload all ones; data changes during a frame are ignored.
- Reset asserted in the DATA cycle carrying bit 3 of 8'h3C -> tx_out=1 and ready_out=1 at the next edge; no done pulse; the next accept sends a clean full frame.
- SNAIL_TX_STUFF_EN, data_in=8'h50 -> line 0,1,0,0,1,1,0,1,1,0,0,0,0,1,1; 15-cycle frame; a loopback detector reports exactly one 010.
- SNAIL_TX_STUFF_EN, data_in=8'h80 -> the marker-to-payload 0,1 boundary forces a stuff: 0,1,0,1,1,0,0,0,0,0,0,0 then the gap; the detector fires once.
